// File: rtl/bus_peripheral_timer.sv
// -----------------------------------------------------------------------------
// bus_peripheral_timer
//
// Memory-mapped peripheral on the core's data-memory bus. It holds a reloadable
// 32-bit up-counter with a level interrupt, an LED register, a 7-segment digit
// register, a two-flop synchronized switch input and a free-running systick.
//
// Register map (byte offsets from BASE_ADDR, full 32-bit compare):
//   0x00 TH      RW  reload value
//   0x04 TL      RW  count
//   0x08 TCON    RW  [0] enable, [1] irq enable, [2] irq status
//   0x0C LED     RW  zero-extended on read
//   0x10 SWITCH  RO  synchronized switch levels, zero-extended
//   0x14 DIGI    RW  [11:8] anode select, [7:0] segments
//   0x18 SYSTICK RO  free-running cycle counter
//   Any other address (including misaligned ones) reads 0 and ignores writes.
//
// Ports:
//   clk            system clock, all state updates on posedge
//   reset          asynchronous active-low reset
//   iMemAddr       byte address from the core
//   iMemRead       read strobe
//   iMemWrite      write strobe
//   iMemWriteData  write data
//   oMemReadData   combinational read data (0 unless a read hits a register)
//   iSwitch        asynchronous switch levels
//   oLed           LED register contents
//   oDigi          7-segment register contents
//   oInterrupt     timer interrupt status (TCON[2])
// -----------------------------------------------------------------------------
module bus_peripheral_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_WIDTH = 8,
  parameter int          SW_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          iMemAddr,
  input  logic                 iMemRead,
  input  logic                 iMemWrite,
  input  logic [31:0]          iMemWriteData,
  output logic [31:0]          oMemReadData,
  input  logic [SW_WIDTH-1:0]  iSwitch,
  output logic [LED_WIDTH-1:0] oLed,
  output logic [11:0]          oDigi,
  output logic                 oInterrupt
);

  localparam int NUM_REGS    = 7;
  localparam int IDX_TH      = 0;
  localparam int IDX_TL      = 1;
  localparam int IDX_TCON    = 2;
  localparam int IDX_LED     = 3;
  localparam int IDX_SWITCH  = 4;
  localparam int IDX_DIGI    = 5;
  localparam int IDX_SYSTICK = 6;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]          thReg;
  logic [31:0]          tlReg;
  logic [2:0]           tconReg;
  logic [LED_WIDTH-1:0] ledReg;
  logic [11:0]          digiReg;
  logic [31:0]          systickReg;
  logic [SW_WIDTH-1:0]  swMetaReg;
  logic [SW_WIDTH-1:0]  swSyncReg;

  logic [31:0]          thNext;
  logic [31:0]          tlNext;
  logic [2:0]           tconNext;
  logic [LED_WIDTH-1:0] ledNext;
  logic [11:0]          digiNext;

  // ---------------------------------------------------------------------------
  // Address decode: one exact-match comparator per word register, so any
  // misaligned or out-of-window address simply hits nothing.
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0] regHit;
  logic [NUM_REGS-1:0] regWrite;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gDecode
      assign regHit[gi]   = (iMemAddr == (BASE_ADDR + 32'(gi * 4)));
      assign regWrite[gi] = iMemWrite & regHit[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read path: registers presented as a word array, selected by the decode.
  // Reads see pre-edge state, so a same-cycle write is not visible yet.
  // ---------------------------------------------------------------------------
  logic [31:0] regView [NUM_REGS];

  assign regView[IDX_TH]      = thReg;
  assign regView[IDX_TL]      = tlReg;
  assign regView[IDX_TCON]    = {29'd0, tconReg};
  assign regView[IDX_LED]     = 32'(ledReg);
  assign regView[IDX_SWITCH]  = 32'(swSyncReg);
  assign regView[IDX_DIGI]    = {20'd0, digiReg};
  assign regView[IDX_SYSTICK] = systickReg;

  always_comb begin
    oMemReadData = 32'h0;
    if (iMemRead) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (regHit[i]) begin
          oMemReadData = regView[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Timer next-state
  // ---------------------------------------------------------------------------
  logic tlAtMax;
  logic overflowSet;

  assign tlAtMax     = (tlReg == 32'hFFFF_FFFF);
  // Interrupt request is judged on pre-edge enable bits, so a same-cycle TCON
  // write cannot suppress or invent an overflow event.
  assign overflowSet = tconReg[0] & tconReg[1] & tlAtMax;

  always_comb begin
    tlNext = tlReg;
    if (tconReg[0]) begin
      tlNext = tlAtMax ? thReg : (tlReg + 32'd1);
    end
    // A CPU write wins over both counting and reload.
    if (regWrite[IDX_TL]) begin
      tlNext = iMemWriteData;
    end
  end

  always_comb begin
    tconNext = {tconReg[2] | overflowSet, tconReg[1:0]};
    // Status is OR-ed with the overflow event so software clearing the flag
    // in the overflow cycle never loses that interrupt.
    if (regWrite[IDX_TCON]) begin
      tconNext = {iMemWriteData[2] | overflowSet, iMemWriteData[1:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Plain RW registers
  // ---------------------------------------------------------------------------
  always_comb begin
    thNext   = thReg;
    ledNext  = ledReg;
    digiNext = digiReg;
    if (regWrite[IDX_TH]) begin
      thNext = iMemWriteData;
    end
    if (regWrite[IDX_LED]) begin
      ledNext = iMemWriteData[LED_WIDTH-1:0];
    end
    if (regWrite[IDX_DIGI]) begin
      digiNext = iMemWriteData[11:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state. SWITCH and SYSTICK have no write path: writes to them
  // fall through the decode without effect.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thReg      <= '0;
      tlReg      <= '0;
      tconReg    <= '0;
      ledReg     <= '0;
      digiReg    <= '0;
      systickReg <= '0;
    end else begin
      thReg      <= thNext;
      tlReg      <= tlNext;
      tconReg    <= tconNext;
      ledReg     <= ledNext;
      digiReg    <= digiNext;
      systickReg <= systickReg + 32'd1;
    end
  end

  // Two-flop synchronizer, one chain per switch bit.
  generate
    for (genvar gi = 0; gi < SW_WIDTH; gi++) begin : gSwSync
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          swMetaReg[gi] <= 1'b0;
          swSyncReg[gi] <= 1'b0;
        end else begin
          swMetaReg[gi] <= iSwitch[gi];
          swSyncReg[gi] <= swMetaReg[gi];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign oLed       = ledReg;
  assign oDigi      = digiReg;
  assign oInterrupt = tconReg[2];

endmodule
